// File: rtl/tybec_leaf_map_pipe_if.sv
// rtl/tybec_leaf_map_pipe_if.sv - handshake bundle for the leaf map pipeline
interface tybec_leaf_map_pipe_if #(
  parameter int DATAW = 32
);
  logic             ivalid_in1;
  logic [DATAW-1:0] in1;
  logic             ivalid_in2;
  logic [DATAW-1:0] in2;
  logic             iready;
  logic             ovalid;
  logic [DATAW-1:0] out1;
  logic             oready;
  logic             busy;

  modport master (
    output ivalid_in1, in1, ivalid_in2, in2, oready,
    input  iready, ovalid, out1, busy
  );

  modport slave (
    input  ivalid_in1, in1, ivalid_in2, in2, oready,
    output iready, ovalid, out1, busy
  );
endinterface

// File: rtl/tybec_leaf_map_pipe.sv
// rtl/tybec_leaf_map_pipe.sv - fixed-latency map operator with credit-guarded output buffer
module tybec_leaf_map_pipe #(
  parameter int               DATAW      = 32,
  parameter int               LAT        = 3,
  parameter int               OP         = 2,
  parameter int               USE_CONST  = 1,
  parameter logic [DATAW-1:0] CONST      = 432,
  parameter int               FIFO_DEPTH = 5
) (
  input logic                   clk,
  input logic                   rst,
  tybec_leaf_map_pipe_if.slave  bus
);

  localparam int CW = $clog2(FIFO_DEPTH + LAT + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NS = (LAT > 1) ? LAT - 1 : 1;

  logic [CW-1:0]    count;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    occupancy;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [DATAW-1:0] mem [FIFO_DEPTH];
  logic [DATAW-1:0] opb;
  logic [DATAW-1:0] result;
  logic [DATAW-1:0] push_data;
  logic [NS-1:0]    stage_vld;
  logic [DATAW-1:0] stage_dat [NS];
  logic             iready_w;
  logic             fire;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit covers every slot a result could still need, so the buffer never overflows.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < NS; i++) begin
      inflight = inflight + CW'(stage_vld[i]);
    end
  end

  assign occupancy  = inflight + count;
  assign iready_w   = occupancy < CW'(FIFO_DEPTH);
  assign fire       = iready_w & bus.ivalid_in1 & (bus.ivalid_in2 | (USE_CONST != 0)) & ~rst;
  assign pop        = bus.ovalid & bus.oready;

  assign bus.iready = iready_w;
  assign bus.ovalid = (count != '0);
  assign bus.busy   = (occupancy != '0);
  assign bus.out1   = mem[rd_ptr];

  assign opb = (USE_CONST != 0) ? CONST : bus.in2;

  always_comb begin
    result = '0;
    case (OP)
      0:       result = bus.in1 + opb;
      1:       result = bus.in1 - opb;
      2:       result = bus.in1 * opb;
      default: result = (bus.in1 > opb) ? bus.in1 : opb;
    endcase
  end

  // Result is formed at the accept edge and then simply delayed, so every slot advances each cycle.
  if (LAT > 1) begin : g_pipe
    always_ff @(posedge clk) begin
      if (rst) begin
        stage_vld <= '0;
      end else begin
        stage_vld[0] <= fire;
        for (int i = 1; i < NS; i++) begin
          stage_vld[i] <= stage_vld[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      stage_dat[0] <= result;
      for (int i = 1; i < NS; i++) begin
        stage_dat[i] <= stage_dat[i-1];
      end
    end

    assign push      = stage_vld[NS-1];
    assign push_data = stage_dat[NS-1];
  end else begin : g_comb
    assign stage_vld    = '0;
    assign stage_dat[0] = '0;
    assign push         = fire;
    assign push_data    = result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: tb/tb_tybec_leaf_map_pipe.sv
// tb/tb_tybec_leaf_map_pipe.sv - scoreboard bench over four operator configurations
module tb_tybec_leaf_map_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ivalid_in1;
  logic [31:0] in1;
  logic        ivalid_in2;
  logic [31:0] in2;
  logic        oready;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input int op, input int uc, input logic [31:0] c,
                                        input logic [31:0] a, input logic [31:0] b_in);
    logic [63:0] w;
    logic [31:0] b;
    b = (uc != 0) ? c : b_in;
    case (op)
      0:       w = {32'd0, a} + {32'd0, b};
      1:       w = {32'd0, a} + {32'd0, ~b} + 64'd1;
      2:       w = {32'd0, a} * {32'd0, b};
      default: w = (a >= b) ? {32'd0, a} : {32'd0, b};
    endcase
    return w[31:0];
  endfunction

  // g0: mul by 432, g1: sub, g2: max with LAT=1/depth 2, g3: add all-ones (wraps)
  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int          L = (g < 2) ? 3 : (g == 2) ? 1 : 2;
    localparam int          O = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 0;
    localparam int          U = (g == 0 || g == 3) ? 1 : 0;
    localparam logic [31:0] C = (g == 3) ? 32'hFFFF_FFFF : 32'd432;
    localparam int          D = (g == 2) ? 2 : (g == 3) ? 3 : 5;

    tybec_leaf_map_pipe_if #(.DATAW(32)) bus ();
    assign bus.ivalid_in1 = ivalid_in1;
    assign bus.in1        = in1;
    assign bus.ivalid_in2 = ivalid_in2;
    assign bus.in2        = in2;
    assign bus.oready     = oready;

    tybec_leaf_map_pipe #(
      .DATAW(32), .LAT(L), .OP(O), .USE_CONST(U), .CONST(C), .FIFO_DEPTH(D)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
    );

    logic        fire_w;
    logic [31:0] sb_d[$];
    int          sb_a[$];
    int          acc_cnt = 0;
    int          pop_cnt = 0;

    assign fire_w = bus.iready & ivalid_in1 & (ivalid_in2 | (U != 0)) & ~rst;

    always @(negedge clk) begin
      if (rst) begin
        sb_d.delete();
        sb_a.delete();
      end else begin
        check($sformatf("g%0d_iready", g), {31'd0, bus.iready}, {31'd0, sb_d.size() < D});
        check($sformatf("g%0d_busy", g), {31'd0, bus.busy}, {31'd0, sb_d.size() != 0});
        check($sformatf("g%0d_ovalid", g), {31'd0, bus.ovalid},
              {31'd0, (sb_d.size() != 0) && (sb_a[0] + L - 1 <= cyc)});
        if (bus.ovalid && oready) begin
          if (sb_d.size() == 0) begin
            check($sformatf("g%0d_extra_out", g), 32'd1, 32'd0);
          end else begin
            check($sformatf("g%0d_out1", g), bus.out1, sb_d[0]);
            void'(sb_d.pop_front());
            void'(sb_a.pop_front());
            pop_cnt++;
          end
        end
        if (fire_w) begin
          sb_d.push_back(model(O, U, C, in1, in2));
          sb_a.push_back(cyc + 1);
          acc_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    ivalid_in1 = 1'b0;
    ivalid_in2 = 1'b0;
    oready     = 1'b1;
    while ((gen_dut[0].bus.busy | gen_dut[1].bus.busy | gen_dut[2].bus.busy |
            gen_dut[3].bus.busy) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int a0, p0, n, k;
    logic got;
    rst = 1'b1; ivalid_in1 = 1'b0; ivalid_in2 = 1'b0; in1 = '0; in2 = '0; oready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_ovalid", {31'd0, gen_dut[0].bus.ovalid}, 32'd0);
    check("rst_busy", {31'd0, gen_dut[0].bus.busy}, 32'd0);
    check("rst_iready", {31'd0, gen_dut[0].bus.iready}, 32'd1);

    // single item: latency and busy span
    a0 = gen_dut[0].acc_cnt;
    ivalid_in1 = 1'b1; in1 = 32'd10; ivalid_in2 = 1'b1; in2 = $urandom;
    tick();
    ivalid_in1 = 1'b0; ivalid_in2 = 1'b0;
    check("s1_accept", gen_dut[0].acc_cnt - a0, 32'd1);
    n = 0;
    while (!gen_dut[0].bus.ovalid && n < 10) begin
      check("s1_busy_inflight", {31'd0, gen_dut[0].bus.busy}, 32'd1);
      tick();
      n++;
    end
    check("s1_latency_edges", n, 32'd2);
    check("s1_out1", gen_dut[0].bus.out1, 32'd4320);
    check("s1_busy_buffered", {31'd0, gen_dut[0].bus.busy}, 32'd1);
    oready = 1'b1;
    tick();
    check("s1_busy_after_pop", {31'd0, gen_dut[0].bus.busy}, 32'd0);
    drain();

    // full-rate stream
    a0 = gen_dut[0].acc_cnt; p0 = gen_dut[0].pop_cnt;
    for (int i = 1; i <= 20; i++) begin
      ivalid_in1 = 1'b1; in1 = i; ivalid_in2 = 1'b1; in2 = $urandom;
      tick();
    end
    check("s2_accepts", gen_dut[0].acc_cnt - a0, 32'd20);
    drain();
    check("s2_pops", gen_dut[0].pop_cnt - p0, 32'd20);

    // backpressure fill to depth
    oready = 1'b0;
    a0 = gen_dut[0].acc_cnt; p0 = gen_dut[0].pop_cnt;
    for (int i = 0; i < 12; i++) begin
      ivalid_in1 = 1'b1; in1 = 100 + i; ivalid_in2 = 1'b1; in2 = $urandom;
      tick();
    end
    check("s3_accepts", gen_dut[0].acc_cnt - a0, 32'd5);
    check("s3_iready_full", {31'd0, gen_dut[0].bus.iready}, 32'd0);
    drain();
    check("s3_pops", gen_dut[0].pop_cnt - p0, 32'd5);

    // second operand arrives late
    oready = 1'b0;
    a0 = gen_dut[1].acc_cnt;
    ivalid_in1 = 1'b1; in1 = 32'd5; ivalid_in2 = 1'b0; in2 = 32'd7;
    tick(); tick();
    check("s4_no_accept", gen_dut[1].acc_cnt - a0, 32'd0);
    ivalid_in2 = 1'b1;
    tick();
    ivalid_in1 = 1'b0; ivalid_in2 = 1'b0;
    check("s4_accept", gen_dut[1].acc_cnt - a0, 32'd1);
    n = 0;
    while (!gen_dut[1].bus.ovalid && n < 10) begin
      tick();
      n++;
    end
    check("s4_out1", gen_dut[1].bus.out1, 32'hFFFF_FFFE);
    drain();

    // reset with two in flight and two buffered
    oready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ivalid_in1 = 1'b1; in1 = 50 + i; ivalid_in2 = 1'b1; in2 = $urandom;
      tick();
    end
    check("s5_pre_ovalid", {31'd0, gen_dut[0].bus.ovalid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; ivalid_in1 = 1'b0; ivalid_in2 = 1'b0;
    check("s5_ovalid", {31'd0, gen_dut[0].bus.ovalid}, 32'd0);
    check("s5_busy", {31'd0, gen_dut[0].bus.busy}, 32'd0);
    check("s5_iready", {31'd0, gen_dut[0].bus.iready}, 32'd1);
    oready = 1'b1;
    repeat (8) tick();

    // random traffic with 30% downstream duty
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ivalid_in1 = 1'b0;
        oready = ($urandom_range(0, 9) < 3);
        tick();
      end
      ivalid_in1 = 1'b1; in1 = $urandom; in2 = $urandom;
      ivalid_in2 = ($urandom_range(0, 4) != 0);
      k = 0;
      do begin
        oready = ($urandom_range(0, 9) < 3);
        @(negedge clk);
        got = gen_dut[0].fire_w;
        tick();
        k++;
      end while (!got && k < 60);
      if (!got) check("s6_accept_timeout", 32'd0, 32'd1);
    end
    drain();
    check("s6_g0_idle", {31'd0, gen_dut[0].bus.busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tybec_leaf_map_pipe.md
TYBEC_LEAF_MAP_PIPE -- requirements
Module: tybec_leaf_map_pipe

Interface
REQ-001 The block SHALL have parameter DATAW, default 32, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter LAT, default 3, meaning total latency in cycles; legal range 1..8.
REQ-003 The block SHALL have parameter OP, default 2, meaning operation: 0 add, 1 sub (in1-in2), 2 mul, 3 unsigned max.
REQ-004 The block SHALL have parameter USE_CONST, default 1, meaning that when 1 the second operand is CONST and the in2 channel is ignored.
REQ-005 The block SHALL have parameter CONST, default 432, meaning the constant second operand, DATAW bits.
REQ-006 The block SHALL have parameter FIFO_DEPTH, default 5, meaning output buffer entries; legal range at least LAT+1.
REQ-007 Port clk SHALL be an input, 1 bit wide: the clock; all state updates on the rising edge.
REQ-008 Port rst SHALL be an input, 1 bit wide: reset, synchronous, active-high.
REQ-009 Port ivalid_in1 SHALL be an input, 1 bit wide: in1 holds valid data.
REQ-010 Port in1 SHALL be an input, DATAW bits wide: first operand.
REQ-011 Port ivalid_in2 SHALL be an input, 1 bit wide: in2 holds valid data; ignored when USE_CONST=1.
REQ-012 Port in2 SHALL be an input, DATAW bits wide: second operand.
REQ-013 Port iready SHALL be an output, 1 bit wide: the block accepts an input set this cycle.
REQ-014 Port ovalid SHALL be an output, 1 bit wide: out1 holds a valid result.
REQ-015 Port out1 SHALL be an output, DATAW bits wide: result at the head of the output buffer.
REQ-016 Port oready SHALL be an input, 1 bit wide: downstream accepts out1 this cycle.
REQ-017 Port busy SHALL be an output, 1 bit wide: at least one item is in flight or buffered.

Function
REQ-018 Accept (fire) SHALL be defined as iready & ivalid_in1 & (ivalid_in2 | USE_CONST); both channels SHALL be consumed together on fire.
REQ-019 iready SHALL equal (inflight + count) < FIFO_DEPTH, computed from registered state only, and SHALL NOT depend combinationally on ivalid_* or oready.
REQ-020 The pipeline SHALL never stall: each stage SHALL advance every cycle, and a per-stage valid bit SHALL mark occupied slots.
REQ-021 inflight SHALL be the number of set stage valid bits; count SHALL be the output-buffer occupancy.
REQ-022 A result accepted on edge k SHALL be written into the buffer on edge k+LAT-1 and be presented with ovalid=1 from the cycle after that edge, giving LAT cycles of latency; for LAT=1 the result is computed combinationally and written on the accept edge.
REQ-023 Add, sub and mul SHALL produce the low DATAW bits of the exact result, wrapping modulo 2^DATAW with no overflow flag; max SHALL compare unsigned.
REQ-024 ovalid SHALL equal (count != 0) and SHALL NOT be gated by oready.
REQ-025 A pop SHALL occur when ovalid & oready; out1 SHALL hold stable while ovalid=1 and oready=0.
REQ-026 On simultaneous push and pop, count SHALL stay unchanged and ordering SHALL be preserved, including at the full boundary.
REQ-027 Pop on an empty buffer SHALL be impossible because ovalid=0; push on a full buffer SHALL be impossible by the credit rule in REQ-019.
REQ-028 Results SHALL leave in strict acceptance order.
REQ-029 With FIFO_DEPTH >= LAT+1 and oready held high, throughput SHALL be one result per cycle.
REQ-030 Buffer read and write pointers SHALL wrap modulo FIFO_DEPTH, which need not be a power of two.
REQ-031 busy SHALL equal (inflight + count) != 0.
REQ-032 out1 SHALL be don't-care whenever ovalid=0.

Reset
REQ-033 On rst=1 at an edge, all stage valid bits, count and both pointers SHALL clear, so ovalid=0, busy=0 and iready=1 in the following cycle.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight and buffered items, with no result emerging afterwards.
REQ-035 Data registers need not be reset.
REQ-036 An input presented in the same cycle as rst=1 SHALL NOT be accepted.

Verification
REQ-037 Scenario 1 (DATAW=32, LAT=3, OP=2, USE_CONST=1, CONST=432): single input in1=10 -> out1=4320 with ovalid=1 exactly 3 cycles after the accept edge; busy=1 from the accept edge until the pop.
REQ-038 Scenario 2 (same configuration): stream 1..20 with oready=1 -> 20 results 432..8640 in order, one per cycle, and iready never drops.
REQ-039 Scenario 3 (same configuration, FIFO_DEPTH=5): hold oready=0 and offer continuous inputs -> exactly 5 accepted and iready=0 thereafter; raise oready -> all 5 drain in order with no loss or duplication.
REQ-040 Scenario 4 (OP=1, USE_CONST=0): in1=5 and in2=7 with ivalid_in2 asserted two cycles late -> no accept until both valid; out1=0xFFFFFFFE.
REQ-041 Scenario 5: assert rst with 2 items in flight and 2 buffered -> next cycle ovalid=0, busy=0, iready=1, and no stale result ever appears.
REQ-042 Scenario 6: random oready with 30% duty over 1000 random inputs -> scoreboard matches the reference model and ordering is preserved.
